block_mem_responder: RTL and testbench
======================================

// Module: block_mem_responder
// PURPOSE
//  Memory-side responder for the dcache block-transfer interface (28-bit block address, 128-bit line).
//  Accepts one read or write request, holds busywait for a programmable latency,
//  then returns or commits a full cache line.
//  Sits under the cache-select mux as the single shared backing store for all four dcache instances.
//  Replaces the fixed-delay behavioural memory with a synthesizable, cycle-exact FSM.
// PARAMETERS
//  ADDR_BITS  8   index bits taken from block address; DEPTH = 2**ADDR_BITS lines
//  LATENCY    5   BUSY-state cycles per access; legal range 1..255
// PORTS
//  clock          in   1    clock; all state updates on posedge
//  reset          in   1    reset, asynchronous, active-high
//  read           in   1    line read request; held by initiator until busywait low
//  write          in   1    line write request; held by initiator until busywait low
//  address        in   28   block address; bits [ADDR_BITS-1:0] index, upper bits ignored (alias)
//  writedata      in   128  line to write; sampled at acceptance
//  readdata       out  128  registered line; valid in DONE cycle, held until next read completes
//  busywait       out  1    high while request pending; low in DONE cycle
//  protocol_error out  1    sticky; set on illegal initiator behaviour, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, readdata=0, protocol_error=0, all lines cleared to 0.
//   busywait forced 0 while reset high.
//  busywait = (state==IDLE && (read|write)) | (state==BUSY). Combinational, so it rises in the request cycle.
//  IDLE: if read|write at posedge -> BUSY.
//   Latch address index, writedata and is_write (write has priority).
//   Load cnt = LATENCY-1.
//  read&write both high in IDLE: treated as write; protocol_error <= 1.
//  BUSY: cnt != 0 -> cnt-1.
//   cnt==0 -> DONE: write commits latched data to array[idx]; read loads readdata <= array[idx].
//  BUSY abort: read and write both low at a posedge -> IDLE.
//   No commit; readdata unchanged; protocol_error <= 1.
//  BUSY type change (latched is_write != current write, request still present):
//   protocol_error <= 1; latched type wins.
//  DONE: one cycle, busywait=0; unconditionally -> IDLE. A request still held here is not re-accepted.
//  Latency: busywait high exactly LATENCY+1 consecutive cycles, then DONE; access-to-access minimum LATENCY+2 cycles.
//  Back-to-back (writeback then fetch): a request present in the IDLE cycle after DONE is accepted normally.
//  readdata is updated only on completed reads; writes never disturb it.
//  Reset mid-operation: immediate IDLE, any pending write dropped, outputs to reset values.
// STRUCTURE
//  Shared package cache_mem_pkg:
//   BLOCK_ADDR_W=28, BLOCK_DATA_W=128;
//   responder state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   Also used by dcache and the cache-select controller.
//  Sub-module block_mem_array: DEPTH x 128 storage.
//   Synchronous write port and synchronous read port on the BUSY->DONE edge.
//   Async clear on reset.
//  FSM, counter, request latches and error logic live in block_mem_responder.
// TESTING
//  1 Reset then idle: read=write=0 for 10 cycles -> busywait=0, readdata=0, protocol_error=0.
//  2 Write then read, LATENCY=5:
//    write addr 28'h0000012, data 128'hDEAD..BEEF -> busywait high 6 cycles, low 1;
//    read same addr -> readdata=128'hDEAD..BEEF in DONE cycle.
//  3 Alias: write 28'h0000112 with 128'h1, read 28'h0000012 (ADDR_BITS=8) -> readdata=128'h1.
//  4 Abort: read accepted, read dropped after 2 BUSY cycles -> IDLE, busywait=0, readdata unchanged, protocol_error=1.
//  5 Reset mid-write: write accepted, reset at BUSY cnt=2 -> busywait=0; following read of that addr returns 0.
//  6 Back-to-back: write addr A then read addr B with request held across DONE ->
//    two distinct accesses, no re-accept in DONE, total 14 cycles at LATENCY=5; LATENCY=1 -> busywait 2 cycles.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared block-transfer definitions for dcache, cache-select controller and memory responder.
//   BLOCK_ADDR_W / BLOCK_DATA_W : block address and cache line widths
//   resp_state_t                : responder FSM encoding
//   line_req_t                  : request payload latched on acceptance
package cache_mem_pkg;

   localparam int unsigned BLOCK_ADDR_W = 28;
   localparam int unsigned BLOCK_DATA_W = 128;
   localparam int unsigned RESP_CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } resp_state_t;

   typedef struct packed {
      logic                    is_write;
      logic [BLOCK_DATA_W-1:0] data;
   } line_req_t;

endpackage

// File: rtl/block_mem_array.sv
// Line storage for the block memory responder.
//   clock, reset : clock, async active-high clear of all lines and read register
//   i_we         : commit i_wdata to line i_idx at posedge
//   i_re         : load o_rdata from line i_idx at posedge
//   i_idx        : line index
//   i_wdata      : line to write
//   o_rdata      : registered read line, held until the next i_re
module block_mem_array
   import cache_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_we,
   input  logic                    i_re,
   input  logic [ADDR_BITS-1:0]    i_idx,
   input  logic [BLOCK_DATA_W-1:0] i_wdata,
   output logic [BLOCK_DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   logic [BLOCK_DATA_W-1:0] r_mem [DEPTH];
   logic [BLOCK_DATA_W-1:0] r_rdata;

   // Storage and read register; whole array clears on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_idx] <= i_wdata;
         end
         if (i_re) begin
            r_rdata <= r_mem[i_idx];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder for the dcache block-transfer interface.
// Accepts one line read or write, holds busywait for LATENCY BUSY cycles,
// then commits or returns the line in a single DONE cycle.
//   clock, reset   : clock, async active-high reset
//   read, write    : line requests, held by the initiator until busywait low
//   address        : block address; low ADDR_BITS index the array, upper bits alias
//   writedata      : line to write, sampled at acceptance
//   readdata       : registered line, updated only by completed reads
//   busywait       : high while a request is pending, low in DONE
//   protocol_error : sticky flag for illegal initiator behaviour
module block_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [BLOCK_ADDR_W-1:0] address,
   input  logic [BLOCK_DATA_W-1:0] writedata,
   output logic [BLOCK_DATA_W-1:0] readdata,
   output logic                    busywait,
   output logic                    protocol_error
);

   resp_state_t             r_state;
   logic [RESP_CNT_W-1:0]   r_cnt;
   line_req_t               r_req;
   logic [ADDR_BITS-1:0]    r_idx;
   logic                    r_protocol_error;

   resp_state_t             w_state_nxt;
   logic [RESP_CNT_W-1:0]   w_cnt_nxt;
   line_req_t               w_req_nxt;
   logic [ADDR_BITS-1:0]    w_idx_nxt;
   logic                    w_err_nxt;
   logic                    w_we;
   logic                    w_re;
   logic                    w_req_any;
   logic                    w_unused_addr;

   assign w_req_any = read | write;

   // Upper block-address bits alias onto the same lines.
   assign w_unused_addr = ^address[BLOCK_ADDR_W-1:ADDR_BITS];

   // State, counter, request latch and sticky error registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_req            <= '0;
         r_idx            <= '0;
         r_protocol_error <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         r_req            <= w_req_nxt;
         r_idx            <= w_idx_nxt;
         r_protocol_error <= w_err_nxt;
      end
   end

   // Next-state, latch, commit/load strobes and error detection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = r_req;
      w_idx_nxt   = r_idx;
      w_err_nxt   = r_protocol_error;
      w_we        = 1'b0;
      w_re        = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_req_any) begin
               w_state_nxt        = BUSY;
               w_cnt_nxt          = RESP_CNT_W'(LATENCY - 1);
               // Write wins when both are raised together.
               w_req_nxt.is_write = write;
               w_req_nxt.data     = writedata;
               w_idx_nxt          = address[ADDR_BITS-1:0];
               if (read && write) begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         BUSY: begin
            if (!w_req_any) begin
               // Initiator dropped the request: abandon without commit.
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               // Request type flipped mid-access; the latched type still completes.
               if (r_req.is_write != write) begin
                  w_err_nxt = 1'b1;
               end
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - RESP_CNT_W'(1);
               end else begin
                  w_state_nxt = DONE;
                  w_we        = r_req.is_write;
                  w_re        = !r_req.is_write;
               end
            end
         end

         // Single handshake cycle; a still-held request is not re-accepted here.
         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   block_mem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_idx   (r_idx),
      .i_wdata (r_req.data),
      .o_rdata (readdata)
   );

   // Combinational so the initiator sees busywait in the request cycle itself.
   assign busywait = !reset &&
                     (((r_state == IDLE) && w_req_any) || (r_state == BUSY));

   assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_block_mem_responder.sv
module tb_block_mem_responder;

   logic         clock = 1'b0;
   logic         reset;
   logic         read, write;
   logic [27:0]  address;
   logic [127:0] writedata, readdata;
   logic         busywait, protocol_error;

   logic         read1, write1;
   logic [27:0]  address1;
   logic [127:0] writedata1, readdata1;
   logic         busywait1, protocol_error1;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] D_BEEF = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
   localparam logic [127:0] D_X    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_Y    = 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0;
   localparam logic [127:0] D_Z    = 128'h0F0F_0F0F_F0F0_F0F0_CAFE_BABE_FACE_B00C;
   localparam logic [127:0] D_V    = 128'h7777_0000_0000_0000_0000_0000_0000_0001;

   always #5 clock = ~clock;

   block_mem_responder #(.ADDR_BITS(8), .LATENCY(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .read           (read),
      .write          (write),
      .address        (address),
      .writedata      (writedata),
      .readdata       (readdata),
      .busywait       (busywait),
      .protocol_error (protocol_error)
   );

   block_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_l1 (
      .clock          (clock),
      .reset          (reset),
      .read           (read1),
      .write          (write1),
      .address        (address1),
      .writedata      (writedata1),
      .readdata       (readdata1),
      .busywait       (busywait1),
      .protocol_error (protocol_error1)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Issue one request on the LATENCY=5 instance; returns with the bench in the DONE cycle.
   task automatic access(input logic rd, input logic wr, input logic [27:0] a,
                         input logic [127:0] d, output int nbusy);
      @(negedge clock);
      read = rd; write = wr; address = a; writedata = d;
      #1;
      nbusy = 0;
      while (busywait && nbusy < 100) begin
         nbusy++;
         tick();
      end
      read = 1'b0; write = 1'b0;
   endtask

   int n, total;

   initial begin
      reset = 1'b1; read = 1'b1; write = 1'b0; address = '0; writedata = '0;
      read1 = 1'b0; write1 = 1'b0; address1 = '0; writedata1 = '0;
      #2;
      chk("rst_busywait_forced_low", busywait, 0);
      chk("rst_readdata", readdata, 0);
      @(negedge clock);
      read = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_busywait", busywait, 0);
      end
      chk("idle_readdata", readdata, 0);
      chk("idle_perr", protocol_error, 0);

      // 2: write then read
      access(1'b0, 1'b1, 28'h0000012, D_BEEF, n);
      chk("wr_busy_cycles", n, 6);
      chk("wr_done_busywait", busywait, 0);
      chk("wr_no_readdata_change", readdata, 0);
      access(1'b1, 1'b0, 28'h0000012, '0, n);
      chk("rd_busy_cycles", n, 6);
      chk("rd_data", readdata, D_BEEF);

      // 3: alias of upper address bits
      access(1'b0, 1'b1, 28'h0000112, 128'h1, n);
      access(1'b1, 1'b0, 28'h0000012, '0, n);
      chk("alias_data", readdata, 128'h1);
      chk("alias_perr", protocol_error, 0);

      // 4: read abandoned after two BUSY cycles
      @(negedge clock);
      read = 1'b1; address = 28'h0000055;
      #1;
      chk("abort_req_busy", busywait, 1);
      tick();
      tick();
      @(negedge clock);
      read = 1'b0;
      #1;
      chk("abort_still_busy", busywait, 1);
      tick();
      chk("abort_busywait", busywait, 0);
      chk("abort_readdata_kept", readdata, 128'h1);
      chk("abort_perr", protocol_error, 1);
      tick();
      chk("abort_stays_idle", busywait, 0);

      // 5: reset while a write is at cnt=2
      @(negedge clock);
      write = 1'b1; address = 28'h0000077; writedata = 128'hCAFE;
      #1;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rstmid_busywait", busywait, 0);
      chk("rstmid_perr", protocol_error, 0);
      chk("rstmid_readdata", readdata, 0);
      @(negedge clock);
      write = 1'b0;
      reset = 1'b0;
      access(1'b0, 1'b1, 28'h0000020, D_Z, n);
      access(1'b1, 1'b0, 28'h0000077, '0, n);
      chk("rstmid_dropped_write", readdata, 0);
      access(1'b1, 1'b0, 28'h0000012, '0, n);
      chk("rstmid_array_cleared", readdata, 0);

      // 6: write A then read B held across DONE
      access(1'b0, 1'b1, 28'h0000041, D_Y, n);
      @(negedge clock);
      write = 1'b1; address = 28'h0000040; writedata = D_X;
      #1;
      total = 0;
      while (busywait && total < 100) begin
         total++;
         tick();
      end
      chk("b2b_first_busy", total, 6);
      write = 1'b0; read = 1'b1; address = 28'h0000041;
      total++;
      tick();
      n = 0;
      while (busywait && n < 100) begin
         n++;
         tick();
      end
      read = 1'b0;
      total += n + 1;
      chk("b2b_second_busy", n, 6);
      chk("b2b_total_cycles", total, 14);
      chk("b2b_read_data", readdata, D_Y);
      access(1'b1, 1'b0, 28'h0000040, '0, n);
      chk("b2b_write_committed", readdata, D_X);
      chk("b2b_perr", protocol_error, 0);

      // 7: read and write together -> write, sticky error
      access(1'b1, 1'b1, 28'h0000060, D_Z, n);
      chk("both_busy_cycles", n, 6);
      chk("both_readdata_kept", readdata, D_X);
      chk("both_perr", protocol_error, 1);
      access(1'b1, 1'b0, 28'h0000060, '0, n);
      chk("both_written", readdata, D_Z);
      chk("both_perr_sticky", protocol_error, 1);

      // 8: LATENCY=1 instance
      @(negedge clock);
      write1 = 1'b1; address1 = 28'h0000003; writedata1 = D_V;
      #1;
      n = 0;
      while (busywait1 && n < 100) begin
         n++;
         tick();
      end
      write1 = 1'b0;
      chk("l1_wr_busy_cycles", n, 2);
      @(negedge clock);
      read1 = 1'b1;
      #1;
      n = 0;
      while (busywait1 && n < 100) begin
         n++;
         tick();
      end
      read1 = 1'b0;
      chk("l1_rd_busy_cycles", n, 2);
      chk("l1_rd_data", readdata1, D_V);
      chk("l1_perr", protocol_error1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
